// File: rtl/interface_frame_ctrl.sv
// SPI link controller: frame-end detect, header/sequence validation,
// IDLE/SYNC/RUN/FAULT link FSM and status frame generation.
module interface_frame_ctrl #(
  parameter int          BUFFER_SIZE = 64,
  parameter logic [31:0] MSGID       = 32'h74697277,
  parameter int          GOOD_FRAMES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    spi_ssel,
  input  logic [BUFFER_SIZE-1:0]  rx_data,
  input  logic                    pkg_timeout,
  input  logic [BUFFER_SIZE-49:0] fb_data,
  output logic [BUFFER_SIZE-1:0]  tx_data,
  output logic [BUFFER_SIZE-41:0] cmd_data,
  output logic                    cmd_strobe,
  output logic                    enable,
  output logic [1:0]              link_state,
  output logic [15:0]             frame_cnt,
  output logic [15:0]             err_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    RUN   = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam logic [3:0] GF = GOOD_FRAMES[3:0];

  state_t                  state;
  logic [2:0]              ssel_sr;
  logic [2:0]              ev_d;
  logic                    end_evt;
  logic                    eval;
  logic                    tx_upd;
  logic [7:0]              seq_exp;
  logic [7:0]              seq_echo;
  logic [3:0]              good_cnt;
  logic                    fault_seen;
  logic [BUFFER_SIZE-49:0] fb_snap;

  logic [31:0]             hdr;
  logic [7:0]              seq;
  logic [BUFFER_SIZE-41:0] payload;
  logic                    hdr_ok;
  logic                    good;

  assign hdr     = rx_data[BUFFER_SIZE-1 -: 32];
  assign seq     = rx_data[BUFFER_SIZE-33 -: 8];
  assign payload = rx_data[BUFFER_SIZE-41:0];
  assign hdr_ok  = (hdr == MSGID);
  assign good    = hdr_ok && ((state == IDLE) || (seq == seq_exp));

  assign end_evt    = (ssel_sr[2:1] == 2'b01);
  assign eval       = ev_d[1];
  // Only refresh tx inside the post-frame window and while ssel is high
  assign tx_upd     = (end_evt | (|ev_d)) & ssel_sr[1];
  assign link_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ssel_sr <= 3'b111;
      ev_d    <= '0;
      fb_snap <= '0;
      tx_data <= {MSGID, {(BUFFER_SIZE-32){1'b0}}};
    end else begin
      ssel_sr <= {ssel_sr[1:0], spi_ssel};
      ev_d    <= {ev_d[1:0], end_evt};
      if (end_evt)
        fb_snap <= fb_data;
      if (tx_upd)
        tx_data <= {MSGID, seq_echo, state, enable,
                    fault_seen, 4'b0000, fb_snap};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      enable     <= 1'b0;
      cmd_strobe <= 1'b0;
      cmd_data   <= '0;
      frame_cnt  <= '0;
      err_cnt    <= '0;
      seq_exp    <= '0;
      seq_echo   <= '0;
      good_cnt   <= '0;
      fault_seen <= 1'b0;
    end else begin
      cmd_strobe <= 1'b0;
      if (eval) begin
        if (frame_cnt != 16'hFFFF)
          frame_cnt <= frame_cnt + 16'd1;
        if (!good && err_cnt != 16'hFFFF)
          err_cnt <= err_cnt + 16'd1;
        if (good) begin
          seq_exp  <= seq + 8'd1;
          seq_echo <= seq;
        end
      end
      if (pkg_timeout) begin
        unique case (state)
          SYNC: begin
            state    <= IDLE;
            good_cnt <= '0;
          end
          RUN: begin
            state      <= FAULT;
            enable     <= 1'b0;
            cmd_data   <= '0;
            cmd_strobe <= 1'b1;
            fault_seen <= 1'b1;
          end
          default: ;
        endcase
      end else if (eval) begin
        unique case (state)
          IDLE, FAULT: begin
            if (good) begin
              good_cnt <= 4'd1;
              if (GF == 4'd1) begin
                state      <= RUN;
                enable     <= 1'b1;
                cmd_data   <= payload;
                cmd_strobe <= 1'b1;
                fault_seen <= 1'b0;
              end else begin
                state <= SYNC;
              end
            end
          end
          SYNC: begin
            if (good) begin
              good_cnt <= good_cnt + 4'd1;
              if (good_cnt + 4'd1 == GF) begin
                state      <= RUN;
                enable     <= 1'b1;
                cmd_data   <= payload;
                cmd_strobe <= 1'b1;
                fault_seen <= 1'b0;
              end
            end else begin
              good_cnt <= '0;
            end
          end
          RUN: begin
            cmd_strobe <= 1'b1;
            if (good) begin
              cmd_data <= payload;
            end else begin
              state      <= FAULT;
              enable     <= 1'b0;
              cmd_data   <= '0;
              fault_seen <= 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_interface_frame_ctrl.sv
// Directed bench for interface_frame_ctrl: sync, fault, timeout,
// sequence wrap, SYNC restart and tx_data stability.
module tb_interface_frame_ctrl;

  localparam logic [31:0] MSGID = 32'h74697277;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        spi_ssel = 1'b1;
  logic [63:0] rx_data = '0;
  logic        pkg_timeout = 1'b0;
  logic [15:0] fb_data = 16'h1234;
  logic [63:0] tx_data;
  logic [23:0] cmd_data;
  logic        cmd_strobe;
  logic        enable;
  logic [1:0]  link_state;
  logic [15:0] frame_cnt;
  logic [15:0] err_cnt;

  int checks = 0;
  int failures = 0;
  int strobes = 0;

  interface_frame_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .spi_ssel    (spi_ssel),
    .rx_data     (rx_data),
    .pkg_timeout (pkg_timeout),
    .fb_data     (fb_data),
    .tx_data     (tx_data),
    .cmd_data    (cmd_data),
    .cmd_strobe  (cmd_strobe),
    .enable      (enable),
    .link_state  (link_state),
    .frame_cnt   (frame_cnt),
    .err_cnt     (err_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (cmd_strobe) strobes++;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send(input logic [31:0] hdr,
                      input logic [7:0]  seq,
                      input logic [23:0] pl,
                      input logic        tmo);
    @(negedge clk);
    spi_ssel = 1'b0;
    repeat (6) @(negedge clk);
    rx_data  = {hdr, seq, pl};
    spi_ssel = 1'b1;
    repeat (4) @(negedge clk);
    pkg_timeout = tmo;
    @(negedge clk);
    pkg_timeout = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  int s0;
  int changes;
  logic [63:0] tx0;
  logic [15:0] exp_fb;

  initial begin
    do_reset();
    check("rst_state", 64'(link_state), 64'd0);
    check("rst_enable", 64'(enable), 64'd0);
    check("rst_cmd", 64'(cmd_data), 64'd0);
    check("rst_strobe", 64'(cmd_strobe), 64'd0);
    check("rst_fcnt", 64'(frame_cnt), 64'd0);
    check("rst_ecnt", 64'(err_cnt), 64'd0);
    check("rst_tx", tx_data, {MSGID, 32'h0});

    // 1: four good frames reach RUN
    s0 = strobes;
    send(MSGID, 8'h10, 24'hAABBCC, 1'b0);
    check("t1_sync", 64'(link_state), 64'd1);
    send(MSGID, 8'h11, 24'hAABBCC, 1'b0);
    send(MSGID, 8'h12, 24'hAABBCC, 1'b0);
    check("t1_sync3", 64'(link_state), 64'd1);
    check("t1_en_off", 64'(enable), 64'd0);
    send(MSGID, 8'h13, 24'hAABBCC, 1'b0);
    check("t1_run", 64'(link_state), 64'd2);
    check("t1_en", 64'(enable), 64'd1);
    check("t1_cmd", 64'(cmd_data), 64'hAABBCC);
    check("t1_strobes", 64'(strobes - s0), 64'd1);
    check("t1_fcnt", 64'(frame_cnt), 64'd4);
    check("t1_ecnt", 64'(err_cnt), 64'd0);
    check("t1_tx", tx_data,
          {MSGID, 8'h13, 2'd2, 1'b1, 1'b0, 4'h0, 16'h1234});

    // 2: repeated sequence number faults the link
    s0 = strobes;
    send(MSGID, 8'h14, 24'h111111, 1'b0);
    check("t2_cmd", 64'(cmd_data), 64'h111111);
    send(MSGID, 8'h14, 24'h222222, 1'b0);
    check("t2_fault", 64'(link_state), 64'd3);
    check("t2_en", 64'(enable), 64'd0);
    check("t2_cmd0", 64'(cmd_data), 64'd0);
    check("t2_ecnt", 64'(err_cnt), 64'd1);
    check("t2_fcnt", 64'(frame_cnt), 64'd6);
    check("t2_strobes", 64'(strobes - s0), 64'd2);
    check("t2_txfault", 64'(tx_data[20]), 64'd1);
    check("t2_txstate", 64'(tx_data[23:22]), 64'd3);

    // recover: FAULT -> SYNC -> RUN
    send(MSGID, 8'h15, 24'h000001, 1'b0);
    check("rec_sync", 64'(link_state), 64'd1);
    send(MSGID, 8'h16, 24'h000002, 1'b0);
    send(MSGID, 8'h17, 24'h000003, 1'b0);
    send(MSGID, 8'h18, 24'h000004, 1'b0);
    check("rec_run", 64'(link_state), 64'd2);
    check("rec_cmd", 64'(cmd_data), 64'h000004);
    check("rec_txfault", 64'(tx_data[20]), 64'd0);

    // 3: timeout coincident with a good evaluation
    send(MSGID, 8'h19, 24'h333333, 1'b1);
    check("t3_fault", 64'(link_state), 64'd3);
    check("t3_cmd0", 64'(cmd_data), 64'd0);
    check("t3_fcnt", 64'(frame_cnt), 64'd11);
    check("t3_ecnt", 64'(err_cnt), 64'd1);

    // 4: sequence wrap in RUN
    do_reset();
    check("t4_rst", 64'(link_state), 64'd0);
    send(MSGID, 8'hFA, 24'h0000FA, 1'b0);
    send(MSGID, 8'hFB, 24'h0000FB, 1'b0);
    send(MSGID, 8'hFC, 24'h0000FC, 1'b0);
    send(MSGID, 8'hFD, 24'h0000FD, 1'b0);
    check("t4_run", 64'(link_state), 64'd2);
    s0 = strobes;
    send(MSGID, 8'hFE, 24'h0000FE, 1'b0);
    send(MSGID, 8'hFF, 24'h0000FF, 1'b0);
    send(MSGID, 8'h00, 24'hC0FF00, 1'b0);
    check("t4_strobes", 64'(strobes - s0), 64'd3);
    check("t4_ecnt", 64'(err_cnt), 64'd0);
    check("t4_state", 64'(link_state), 64'd2);
    check("t4_cmd", 64'(cmd_data), 64'hC0FF00);
    check("t4_fcnt", 64'(frame_cnt), 64'd7);

    // 5: bad header in SYNC restarts the good count
    do_reset();
    send(MSGID, 8'h40, 24'h0, 1'b0);
    send(MSGID, 8'h41, 24'h0, 1'b0);
    send(32'hDEADBEEF, 8'h42, 24'h0, 1'b0);
    check("t5_sync", 64'(link_state), 64'd1);
    check("t5_ecnt", 64'(err_cnt), 64'd1);
    send(MSGID, 8'h42, 24'h0, 1'b0);
    send(MSGID, 8'h43, 24'h0, 1'b0);
    send(MSGID, 8'h44, 24'h0, 1'b0);
    check("t5_still_sync", 64'(link_state), 64'd1);
    send(MSGID, 8'h45, 24'h454545, 1'b0);
    check("t5_run", 64'(link_state), 64'd2);
    check("t5_cmd", 64'(cmd_data), 64'h454545);

    // 6: tx_data stable during frame, fb snapshot at end_evt
    @(negedge clk);
    spi_ssel = 1'b0;
    fb_data  = 16'hA000;
    tx0      = tx_data;
    changes  = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tx_data !== tx0) changes++;
      fb_data = fb_data + 16'd1;
    end
    rx_data  = {MSGID, 8'h46, 24'h464646};
    spi_ssel = 1'b1;
    exp_fb   = 16'h0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      fb_data = 16'hB000 + 16'(k);
      if (k == 2) exp_fb = fb_data;
    end
    repeat (4) @(negedge clk);
    check("t6_stable", 64'(changes), 64'd0);
    check("t6_fb", 64'(tx_data[15:0]), 64'(exp_fb));
    check("t6_tx", tx_data,
          {MSGID, 8'h46, 2'd2, 1'b1, 1'b0, 4'h0, 16'hB002});
    check("t6_cmd", 64'(cmd_data), 64'h464646);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/interface_frame_ctrl.md
Name: interface_frame_ctrl

Overview:
- Link controller that sits between the SPI slave interface and the I/O datapath.
- Detects frame boundaries on SPI_SSEL and validates each received frame by header and 8-bit sequence number.
- Runs a link state machine (IDLE/SYNC/RUN/FAULT) that gates command delivery and the `enable` output to downstream generators.
- Builds the status/feedback frame the slave shifts back to the host, keeping it stable for the whole frame.

Parameters:
- BUFFER_SIZE, 64: SPI frame width in bits; multiple of 8, ≥64.
- MSGID, 32'h74697277: required rx header and the header placed on tx frames.
- GOOD_FRAMES, 4: consecutive valid frames needed in SYNC before entering RUN; range 1..15.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- spi_ssel  in  1  raw SPI_SSEL pin, active low, asynchronous to clk
- rx_data  in  BUFFER_SIZE  latched frame from the SPI slave
- pkg_timeout  in  1  slave timeout flag
- fb_data  in  BUFFER_SIZE-48  feedback payload from the datapath
- tx_data  out  BUFFER_SIZE  frame presented to the SPI slave
- cmd_data  out  BUFFER_SIZE-40  command payload to the datapath
- cmd_strobe  out  1  one-cycle pulse when cmd_data is updated
- enable  out  1  datapath run enable
- link_state  out  2  IDLE=0, SYNC=1, RUN=2, FAULT=3
- frame_cnt  out  16  evaluated frames, saturating
- err_cnt  out  16  rejected frames, saturating

Behaviour:
- One clock; asynchronous active-low reset. No other reset source.
- Reset values:
  - link_state=IDLE
  - enable=0, cmd_strobe=0, cmd_data=0
  - frame_cnt=0, err_cnt=0
  - seq_exp=0, good_cnt=0, fb snapshot=0
  - ssel shift register=3'b111
- Frame-end detect:
  - 3-stage shift of spi_ssel, same alignment as the slave.
  - end_evt when stages [2:1]==2'b01.
- Evaluation:
  - Evaluate at end_evt+2 cycles, after the slave has updated rx_data.
  - hdr = rx_data[BUFFER_SIZE-1 -: 32]
  - seq = rx_data[BUFFER_SIZE-33 -: 8]
  - payload = rx_data[BUFFER_SIZE-41:0]
  - good = (hdr==MSGID) and (seq==seq_exp); the seq check is skipped in IDLE.
  - A frame the slave rejected leaves rx_data stale, so it fails the seq check and counts as bad.
- On every evaluation:
  - frame_cnt+1, saturating at 16'hFFFF.
  - On bad: err_cnt+1, saturating.
  - On good: seq_exp = seq+1, mod 256 (seq 8'hFF is followed by 8'h00).
- State machine (priority per cycle: rst_n > pkg_timeout > evaluation):
  - IDLE: on evaluation with hdr==MSGID → SYNC, good_cnt=1, seq_exp=seq+1. If GOOD_FRAMES==1, go straight to RUN instead.
  - SYNC:
    - good → good_cnt+1; on reaching GOOD_FRAMES → RUN.
    - bad → good_cnt=0, stay in SYNC.
    - pkg_timeout=1 → IDLE, good_cnt=0.
  - RUN:
    - enable=1.
    - good → cmd_data=payload, cmd_strobe=1 for one cycle, registered at evaluation+1.
    - bad or pkg_timeout → FAULT.
  - FAULT:
    - Entry forces enable=0 and cmd_data=0 in the same cycle, and pulses cmd_strobe once.
    - Leave to SYNC (good_cnt=1) on the first good frame while pkg_timeout=0.
    - The seq check still applies; seq_exp tracks the last good seq.
  - The SYNC→RUN transition frame's payload is applied, with a strobe, on entering RUN.
- Timeout vs evaluation: if pkg_timeout rises in the same cycle as an evaluation in RUN, go to FAULT. The frame is counted but not applied.
- enable is a registered function of link_state: 1 only in RUN.
- tx_data is {MSGID, seq_echo[7:0], link_state[1:0], enable, fault_seen, 4'b0, fb_snap}:
  - seq_echo = last good seq.
  - fault_seen sets on FAULT entry and clears on RUN entry.
  - fb_snap is captured from fb_data at end_evt.
- tx_data update rules:
  - tx_data changes only in the window from end_evt to end_evt+3.
  - It never changes while synced ssel is low, so the slave's start-of-frame capture is always coherent.
- Reset asserted mid-frame: state returns to IDLE. The first post-reset frame-end is evaluated normally. A partial frame is harmless, because the slave gates rx_data on the header.

Test Plan:
1. Reset, then 4 frames hdr=MSGID, seq=0x10..0x13, payload=0xAA_BBCC → link_state 0→1→…→2 after the 4th frame; enable=1; cmd_data=0xAABBCC; one cmd_strobe; frame_cnt=4, err_cnt=0.
2. In RUN, send seq 0x14 then a repeat of 0x14 → second frame bad; link_state=3; enable=0; cmd_data=0; err_cnt=1; tx_data fault bit=1.
3. In RUN, assert pkg_timeout on the same cycle as a good-frame evaluation → FAULT; payload not applied; frame_cnt increments.
4. Sequence wrap: in RUN, frames with seq 0xFE, 0xFF, 0x00 → all good; cmd_strobe×3; err_cnt unchanged.
5. In SYNC after 2 good frames, send a bad header (0xDEADBEEF) → good_cnt resets; 4 further good frames are needed to reach RUN.
6. Toggle fb_data continuously while spi_ssel is low → tx_data stable throughout the frame; after frame end it equals the fb_data value sampled at end_evt.
